regfile_rw: RTL and testbench

- 32 x 32-bit processor register file with one write port and two read ports.
- Sits directly downstream of the 5-bit write-address decoder: the decoder's one-hot output selects which register latches the write data.
- Adds registered reads with write-to-read bypass, plus a hardware "clear all" sequencer that zeroes r1..r31 one register per cycle.
- r0 is hardwired zero.

---
 rtl/regfile_rw_pkg.sv | 16 +
 rtl/regfile_rw_if.sv | 29 ++
 rtl/regfile_rw_five_bit_decoder.sv | 15 +
 rtl/regfile_rw.sv | 153 +++++++++++++++
 tb/tb_regfile_rw.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_rw_pkg.sv
// Shared constants and state encoding for the regfile_rw register file.
// Imported by the interface, the write-address decoder and the top.
package regfile_rw_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = 5'd31;

endpackage : regfile_rw_pkg

// File: rtl/regfile_rw_if.sv
// Bus bundle for the register file: one write port, two read ports, clear control.
// The master drives requests; the slave (the register file) returns read data and status.
interface regfile_rw_if;
  import regfile_rw_pkg::*;

  logic                  ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0] ctrl_writeRegister;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic                  ctrl_clear;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;
  logic                  busy;
  logic                  write_dropped;

  modport master (
    output ctrl_writeEnable, ctrl_writeRegister, data_writeReg,
           ctrl_readRegA, ctrl_readRegB, ctrl_clear,
    input  data_readRegA, data_readRegB, busy, write_dropped
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeRegister, data_writeReg,
           ctrl_readRegA, ctrl_readRegB, ctrl_clear,
    output data_readRegA, data_readRegB, busy, write_dropped
  );

endinterface : regfile_rw_if

// File: rtl/regfile_rw_five_bit_decoder.sv
// 5-to-32 one-hot decoder selecting the register that receives write data.
module five_bit_decoder
  import regfile_rw_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] sel,
  output logic [NUM_REGS-1:0]   onehot
);

  // One-hot decode of the select input.
  always_comb begin
    onehot      = {NUM_REGS{1'b0}};
    onehot[sel] = 1'b1;
  end

endmodule : five_bit_decoder

// File: rtl/regfile_rw.sv
// 32 x 32-bit register file: one write port, two registered read ports with
// write/clear bypass, r0 hardwired to zero, and a one-register-per-cycle clear sequencer.
module regfile_rw
  import regfile_rw_pkg::*;
(
  input  logic         clock,
  input  logic         ctrl_reset_n,
  regfile_rw_if.slave  bus
);

  state_t                 state_r;
  state_t                 next_state_s;
  logic [ADDR_WIDTH-1:0]  counter_r;
  logic [ADDR_WIDTH-1:0]  counter_nxt_s;

  logic [DATA_WIDTH-1:0]  regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]    dec_s;
  logic [NUM_REGS-1:1]    wr_en_s;
  logic [NUM_REGS-1:1]    clr_en_s;

  logic                   clearing_s;
  logic                   commit_s;
  logic                   drop_s;

  logic [DATA_WIDTH-1:0]  read_a_s;
  logic [DATA_WIDTH-1:0]  read_b_s;
  logic [DATA_WIDTH-1:0]  read_a_r;
  logic [DATA_WIDTH-1:0]  read_b_r;
  logic                   write_dropped_r;

  five_bit_decoder u_wr_dec (
    .sel    (bus.ctrl_writeRegister),
    .onehot (dec_s)
  );

  // Decoder line 0 doubles as the "address is r0" flag so writes there never commit.
  assign clearing_s = (state_r == CLEAR);
  assign commit_s   = (state_r == IDLE) & ~bus.ctrl_clear & bus.ctrl_writeEnable & ~dec_s[0];
  assign drop_s     = bus.ctrl_writeEnable & (clearing_s | bus.ctrl_clear);

  // Per-register write and clear enables.
  always_comb begin
    wr_en_s  = dec_s[NUM_REGS-1:1] & {(NUM_REGS-1){commit_s}};
    clr_en_s = {(NUM_REGS-1){1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      if (clearing_s && (counter_r == ADDR_WIDTH'(i))) begin
        clr_en_s[i] = 1'b1;
      end else begin
        clr_en_s[i] = 1'b0;
      end
    end
  end

  // Clear FSM next-state and counter logic.
  always_comb begin
    next_state_s  = state_r;
    counter_nxt_s = counter_r;
    case (state_r)
      IDLE: begin
        if (bus.ctrl_clear) begin
          next_state_s  = CLEAR;
          counter_nxt_s = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          next_state_s  = IDLE;
          counter_nxt_s = {ADDR_WIDTH{1'b0}};
        end
      end
      CLEAR: begin
        if (counter_r == CLEAR_LAST) begin
          next_state_s  = IDLE;
          counter_nxt_s = {ADDR_WIDTH{1'b0}};
        end else begin
          next_state_s  = CLEAR;
          counter_nxt_s = counter_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        next_state_s  = IDLE;
        counter_nxt_s = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Clear FSM state and counter registers.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_r   <= IDLE;
      counter_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r   <= next_state_s;
      counter_r <= counter_nxt_s;
    end
  end

  // Register storage; entry 0 is never written and stays zero.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (clr_en_s[i]) begin
          regs_r[i] <= {DATA_WIDTH{1'b0}};
        end else if (wr_en_s[i]) begin
          regs_r[i] <= bus.data_writeReg;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Value a read port will capture at this edge, including same-edge write or clear.
  function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] v;
    if (addr == {ADDR_WIDTH{1'b0}}) begin
      v = {DATA_WIDTH{1'b0}};
    end else if (commit_s && (bus.ctrl_writeRegister == addr)) begin
      v = bus.data_writeReg;
    end else if (clearing_s && (counter_r == addr)) begin
      v = {DATA_WIDTH{1'b0}};
    end else begin
      v = regs_r[addr];
    end
    return v;
  endfunction

  // Read-port mux for both ports.
  always_comb begin
    read_a_s = read_value(bus.ctrl_readRegA);
    read_b_s = read_value(bus.ctrl_readRegB);
  end

  // Registered read data and write-dropped pulse.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      read_a_r        <= {DATA_WIDTH{1'b0}};
      read_b_r        <= {DATA_WIDTH{1'b0}};
      write_dropped_r <= 1'b0;
    end else begin
      read_a_r        <= read_a_s;
      read_b_r        <= read_b_s;
      write_dropped_r <= drop_s;
    end
  end

  assign bus.data_readRegA = read_a_r;
  assign bus.data_readRegB = read_b_r;
  assign bus.busy          = clearing_s;
  assign bus.write_dropped = write_dropped_r;

endmodule : regfile_rw

// File: tb/tb_regfile_rw.sv
// Directed bench for regfile_rw: reset, write/read, r0, bypass, clear sequence,
// clear/write conflicts and reset during clear, with hand-computed expectations.
module tb_regfile_rw;
  import regfile_rw_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   busy_cycles;

  regfile_rw_if bus ();

  regfile_rw dut (
    .clock        (clk),
    .ctrl_reset_n (rst_n),
    .bus          (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ctrl_writeEnable   = 1'b0;
    bus.ctrl_writeRegister = 5'd0;
    bus.data_writeReg      = 32'h0;
    bus.ctrl_clear         = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    bus.ctrl_writeEnable   = 1'b1;
    bus.ctrl_writeRegister = a;
    bus.data_writeReg      = d;
    tick();
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    bus.ctrl_readRegA = 5'd0;
    bus.ctrl_readRegB = 5'd0;
    tick();
    tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_drop", {31'd0, bus.write_dropped}, 32'd0);
    chk("rst_a", bus.data_readRegA, 32'h0);
    rst_n = 1'b1;

    // Every register reads zero out of reset on both ports.
    for (int i = 0; i < 32; i++) begin
      bus.ctrl_readRegA = 5'(i);
      bus.ctrl_readRegB = 5'(31 - i);
      tick();
      chk("reset_read_a", bus.data_readRegA, 32'h0);
      chk("reset_read_b", bus.data_readRegB, 32'h0);
    end
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_drop", {31'd0, bus.write_dropped}, 32'd0);

    // Basic write/read.
    bus.ctrl_readRegA = 5'd0;
    do_write(5'd5, 32'hDEADBEEF);
    bus.ctrl_readRegA = 5'd5;
    bus.ctrl_readRegB = 5'd0;
    tick();
    chk("wr5_read_a", bus.data_readRegA, 32'hDEADBEEF);
    chk("wr5_read_b", bus.data_readRegB, 32'h0);
    chk("wr5_drop", {31'd0, bus.write_dropped}, 32'd0);

    // r0 is hardwired zero and a write there is not a drop.
    do_write(5'd0, 32'h12345678);
    chk("r0_drop", {31'd0, bus.write_dropped}, 32'd0);
    bus.ctrl_readRegA = 5'd0;
    bus.ctrl_readRegB = 5'd0;
    tick();
    chk("r0_read_a", bus.data_readRegA, 32'h0);
    chk("r0_read_b", bus.data_readRegB, 32'h0);

    // Same-edge write bypass on both ports.
    bus.ctrl_readRegA = 5'd7;
    bus.ctrl_readRegB = 5'd7;
    do_write(5'd7, 32'hA5A5A5A5);
    chk("bypass_a", bus.data_readRegA, 32'hA5A5A5A5);
    chk("bypass_b", bus.data_readRegB, 32'hA5A5A5A5);

    // Fill r1..r31 with their index.
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i));
    end
    bus.ctrl_readRegA = 5'd31;
    bus.ctrl_readRegB = 5'd5;
    tick();
    chk("fill_r31", bus.data_readRegA, 32'd31);
    chk("fill_r5", bus.data_readRegB, 32'd5);

    // Clear sequence: edge k, then 31 edges of clearing.
    bus.ctrl_readRegA = 5'd31;
    bus.ctrl_readRegB = 5'd1;
    bus.ctrl_clear    = 1'b1;
    tick();
    bus.ctrl_clear = 1'b0;
    busy_cycles = 0;
    chk("clr_k_busy", {31'd0, bus.busy}, 32'd1);
    chk("clr_k_r1", bus.data_readRegB, 32'd1);
    if (bus.busy) busy_cycles++;
    for (int j = 1; j <= 31; j++) begin
      bus.ctrl_clear = (j == 5);
      tick();
      bus.ctrl_clear = 1'b0;
      if (bus.busy) busy_cycles++;
      chk("clr_busy", {31'd0, bus.busy}, (j < 31) ? 32'd1 : 32'd0);
      chk("clr_r31", bus.data_readRegA, (j < 31) ? 32'd31 : 32'd0);
      chk("clr_r1", bus.data_readRegB, 32'd0);
    end
    chk("clr_busy_cycles", 32'(busy_cycles), 32'd31);
    for (int i = 1; i < 32; i++) begin
      bus.ctrl_readRegA = 5'(i);
      bus.ctrl_readRegB = 5'(i);
      tick();
      chk("post_clr_a", bus.data_readRegA, 32'h0);
      chk("post_clr_b", bus.data_readRegB, 32'h0);
    end

    // Clear coincident with a write: the write is dropped.
    do_write(5'd3, 32'h00000077);
    do_write(5'd20, 32'h00002020);
    bus.ctrl_readRegA      = 5'd3;
    bus.ctrl_readRegB      = 5'd20;
    bus.ctrl_clear         = 1'b1;
    bus.ctrl_writeEnable   = 1'b1;
    bus.ctrl_writeRegister = 5'd3;
    bus.data_writeReg      = 32'h00000001;
    tick();
    idle_inputs();
    chk("conf_drop", {31'd0, bus.write_dropped}, 32'd1);
    chk("conf_busy", {31'd0, bus.busy}, 32'd1);
    chk("conf_r3", bus.data_readRegA, 32'h00000077);
    bus.ctrl_readRegA = 5'd20;
    for (int e = 1; e <= 15; e++) begin
      bus.ctrl_writeEnable   = (e == 10);
      bus.ctrl_writeRegister = 5'd9;
      bus.data_writeReg      = 32'hFFFFFFFF;
      tick();
      idle_inputs();
      chk("busy_drop", {31'd0, bus.write_dropped}, (e == 10) ? 32'd1 : 32'd0);
      chk("busy_state", {31'd0, bus.busy}, 32'd1);
    end
    chk("pre_rst_r20", bus.data_readRegA, 32'h00002020);

    // Reset in mid-clear aborts immediately.
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_a", bus.data_readRegA, 32'h0);
    chk("midrst_b", bus.data_readRegB, 32'h0);
    chk("midrst_drop", {31'd0, bus.write_dropped}, 32'd0);
    #3;
    rst_n = 1'b1;
    bus.ctrl_readRegA = 5'd20;
    bus.ctrl_readRegB = 5'd9;
    tick();
    chk("after_rst_r20", bus.data_readRegA, 32'h0);
    chk("after_rst_r9", bus.data_readRegB, 32'h0);
    chk("after_rst_busy", {31'd0, bus.busy}, 32'd0);
    do_write(5'd9, 32'h0BADF00D);
    tick();
    chk("after_rst_wr", bus.data_readRegB, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_rw
